timing_leak_monitor: RTL

TIMING_LEAK_MONITOR -- requirements
Module: timing_leak_monitor

---
 rtl/timing_leak_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/timing_leak_monitor.sv
// ============================================================================
// Module   : timing_leak_monitor
// Purpose  : Measures the start-to-done latency of two multiplier copies and
//            flags a timing leak when they differ or time out.
//            Optional macro LEAK_STICKY_EN makes the leak flag sticky.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timing_leak_monitor #(
   parameter int CNT_WIDTH  = 8,
   parameter int MAX_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 productDoneOne,
   input  logic                 productDoneTwo,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] latencyOne,
   output logic [CNT_WIDTH-1:0] latencyTwo,
   output logic [CNT_WIDTH-1:0] skew,
   output logic                 resultValid,
   output logic                 timeout,
   output logic                 leak,
   output logic [CNT_WIDTH-1:0] leakCount
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_REPORT  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_max = CNT_WIDTH'(MAX_CYCLES);
   localparam logic [CNT_WIDTH-1:0] c_sat = '1;

   state_t               r_state;
   state_t               w_next;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_lat_one;
   logic [CNT_WIDTH-1:0] r_lat_two;
   logic                 r_cap_one;
   logic                 r_cap_two;

   logic [CNT_WIDTH-1:0] w_count;
   logic [CNT_WIDTH-1:0] w_fin_one;
   logic [CNT_WIDTH-1:0] w_fin_two;
   logic [CNT_WIDTH-1:0] w_skew;
   logic                 w_both;
   logic                 w_expire;
   logic                 w_done;
   logic                 w_leaking;

   // w_count is the number of the current MEASURE cycle (first cycle reads 1)
   assign w_count  = r_cnt + CNT_WIDTH'(1);
   assign w_both   = (r_cap_one | productDoneOne) & (r_cap_two | productDoneTwo);
   assign w_expire = (w_count == c_max) & ~w_both;
   assign w_done   = (r_state == S_MEASURE) & (w_both | w_expire);

   // Final latencies as they will be published; an uncaptured side reads c_max
   assign w_fin_one = r_cap_one ? r_lat_one : (productDoneOne ? w_count : c_max);
   assign w_fin_two = r_cap_two ? r_lat_two : (productDoneTwo ? w_count : c_max);
   assign w_skew    = (w_fin_one >= w_fin_two) ? (w_fin_one - w_fin_two)
                                               : (w_fin_two - w_fin_one);
   assign w_leaking = (w_fin_one != w_fin_two) | w_expire;

   assign busy        = (r_state != S_IDLE);
   assign resultValid = (r_state == S_REPORT);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start)  w_next = S_MEASURE;
         S_MEASURE: if (w_done) w_next = S_REPORT;
         S_REPORT:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_lat_one  <= '0;
         r_lat_two  <= '0;
         r_cap_one  <= 1'b0;
         r_cap_two  <= 1'b0;
         latencyOne <= '0;
         latencyTwo <= '0;
         skew       <= '0;
         timeout    <= 1'b0;
         leak       <= 1'b0;
         leakCount  <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            r_cnt     <= '0;
            r_cap_one <= 1'b0;
            r_cap_two <= 1'b0;
         end
         if (r_state == S_MEASURE) begin
            r_cnt <= w_count;
            if (productDoneOne && !r_cap_one) begin
               r_lat_one <= w_count;
               r_cap_one <= 1'b1;
            end
            if (productDoneTwo && !r_cap_two) begin
               r_lat_two <= w_count;
               r_cap_two <= 1'b1;
            end
         end
         // Results are published on entry to REPORT so they are valid with resultValid
         if (w_done) begin
            latencyOne <= w_fin_one;
            latencyTwo <= w_fin_two;
            skew       <= w_skew;
            timeout    <= w_expire;
`ifdef LEAK_STICKY_EN
            leak       <= leak | w_leaking;
`else
            leak       <= w_leaking;
`endif
            if (w_leaking && (leakCount != c_sat)) begin
               leakCount <= leakCount + CNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire
